// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential shift-add floating-point multiplier with valid/ready handshake
// FP_MUL_RNE_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module fp_mul_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     producto,
    output logic                     snan,
    output logic                     qnan,
    output logic                     inf,
    output logic                     zero,
    output logic                     normal
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 1;
    localparam int PW  = 2 * SW;
    localparam int EW2 = EXP_W + 2;
    localparam int CW  = $clog2(SW);

    localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
    localparam logic signed [EW2-1:0] E_MAX  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] E_BIAS = EW2'(BIAS);

    localparam logic [4:0] C_SNAN = 5'b10000;
    localparam logic [4:0] C_QNAN = 5'b01000;
    localparam logic [4:0] C_INF  = 5'b00100;
    localparam logic [4:0] C_ZERO = 5'b00010;
    localparam logic [4:0] C_NORM = 5'b00001;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t                 state;
    logic [4:0]             cls;
    logic                   sign_r;
    logic signed [EW2-1:0]  exp_r;
    logic [SW-1:0]          sig_a;
    logic [SW-1:0]          sig_b;
    logic [PW-1:0]          acc;
    logic [CW-1:0]          cnt;

    assign {snan, qnan, inf, zero, normal} = cls;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic a_snan, a_qnan, a_inf, a_zs, b_snan, b_qnan, b_inf, b_zs, sign_in;

    assign a_exp   = a[W-2:MAN_W];
    assign b_exp   = b[W-2:MAN_W];
    assign a_frac  = a[MAN_W-1:0];
    assign b_frac  = b[MAN_W-1:0];
    assign a_snan  = (&a_exp) & (|a_frac) & ~a_frac[MAN_W-1];
    assign a_qnan  = (&a_exp) & a_frac[MAN_W-1];
    assign a_inf   = (&a_exp) & ~(|a_frac);
    assign a_zs    = ~(|a_exp);
    assign b_snan  = (&b_exp) & (|b_frac) & ~b_frac[MAN_W-1];
    assign b_qnan  = (&b_exp) & b_frac[MAN_W-1];
    assign b_inf   = (&b_exp) & ~(|b_frac);
    assign b_zs    = ~(|b_exp);
    assign sign_in = a[W-1] ^ b[W-1];

    logic           spec_hit;
    logic [W-1:0]   spec_res;
    logic [4:0]     spec_cls;

    // Special operands resolve at capture, in priority order; subnormals count as zero.
    always_comb begin
        spec_hit = 1'b1;
        spec_res = '0;
        spec_cls = '0;
        if (a_snan || b_snan) begin
            spec_res = {sign_in, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            spec_cls = C_SNAN;
        end else if (a_qnan) begin
            spec_res = a;
            spec_cls = C_QNAN;
        end else if (b_qnan) begin
            spec_res = b;
            spec_cls = C_QNAN;
        end else if ((a_inf && b_zs) || (b_inf && a_zs)) begin
            spec_res = {sign_in, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            spec_cls = C_QNAN;
        end else if (a_inf || b_inf) begin
            spec_res = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_cls = C_INF;
        end else if (a_zs || b_zs) begin
            spec_res = {sign_in, {(W-1){1'b0}}};
            spec_cls = C_ZERO;
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic signed [EW2-1:0] e_cap;
    assign e_cap = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - E_BIAS;

    logic                  msb, guard, sticky, rnd;
    logic [MAN_W-1:0]      frac_n, frac_f;
    logic [MAN_W:0]        frac_r;
    logic signed [EW2-1:0] e_n, e_f;

    assign msb    = acc[PW-1];
    assign frac_n = msb ? acc[PW-2 -: MAN_W] : acc[PW-3 -: MAN_W];
    assign guard  = msb ? acc[PW-2-MAN_W] : acc[PW-3-MAN_W];
    assign sticky = msb ? (|acc[PW-3-MAN_W:0]) : (|acc[PW-4-MAN_W:0]);
    assign e_n    = msb ? exp_r + E_ONE : exp_r;

`ifdef FP_MUL_RNE_EN
    assign rnd = guard & (sticky | frac_n[0]);
`else
    logic unused_gs;
    assign unused_gs = guard ^ sticky;
    assign rnd       = 1'b0;
`endif

    assign frac_r = {1'b0, frac_n} + {{MAN_W{1'b0}}, rnd};
    assign e_f    = frac_r[MAN_W] ? e_n + E_ONE : e_n;
    assign frac_f = frac_r[MAN_W] ? '0 : frac_r[MAN_W-1:0];

    logic [W-1:0] norm_res;
    logic [4:0]   norm_cls;

    always_comb begin
        norm_res = '0;
        norm_cls = '0;
        if (e_f >= E_MAX) begin
            norm_res = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_cls = C_INF;
        end else if (e_f < E_ONE) begin
            norm_res = {sign_r, {(W-1){1'b0}}};
            norm_cls = C_ZERO;
        end else begin
            norm_res = {sign_r, e_f[EXP_W-1:0], frac_f};
            norm_cls = C_NORM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            producto  <= '0;
            cls       <= '0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            sig_a     <= '0;
            sig_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        sign_r   <= sign_in;
                        if (spec_hit) begin
                            producto  <= spec_res;
                            cls       <= spec_cls;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            sig_a <= {1'b1, a_frac};
                            sig_b <= {1'b1, b_frac};
                            exp_r <= e_cap;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    // One multiplier bit per cycle, LSB first.
                    if (sig_b[cnt])
                        acc <= acc + ({{SW{1'b0}}, sig_a} << cnt);
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(SW - 1))
                        state <= NORM;
                end
                NORM: begin
                    producto  <= norm_res;
                    cls       <= norm_cls;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cls       <= '0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - scoreboard bench for fp_mul_seq (FP16 build)
module tb_fp_mul_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] producto;
    logic        snan, qnan, inf, zero, normal;
    logic [4:0]  flags_obs;

    assign flags_obs = {snan, qnan, inf, zero, normal};

    fp_mul_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .producto(producto), .snan(snan), .qnan(qnan), .inf(inf),
        .zero(zero), .normal(normal)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] F_SNAN = 5'b10000;
    localparam logic [4:0] F_QNAN = 5'b01000;
    localparam logic [4:0] F_INF  = 5'b00100;
    localparam logic [4:0] F_ZERO = 5'b00010;
    localparam logic [4:0] F_NORM = 5'b00001;
`ifdef FP_MUL_RNE_EN
    localparam logic [15:0] RND_EXP = 16'h4082;
`else
    localparam logic [15:0] RND_EXP = 16'h4081;
`endif

    typedef struct {
        logic [15:0] p;
        logic [4:0]  f;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   lat_obs;

    // Launch one operation; lat_obs counts edges from the accept edge (inclusive) to out_valid.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input bit toggle);
        @(negedge clk);
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat_obs = 1;
        while (out_valid !== 1'b1 && lat_obs < 40) begin
            if (toggle) begin
                a = 16'($urandom);
                b = 16'($urandom);
                in_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat_obs++;
        end
        in_valid = 1'b0;
    endtask

    task automatic release_result;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (producto !== 16'h0) begin errors++; $display("FAIL reset_producto got %h want 0000", producto); end
        checks++; if (flags_obs !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", flags_obs); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_normal;
        logic [15:0] ta[6] = '{16'h3E00, 16'h3E01, 16'h7BFF, 16'h0400, 16'h3C00, 16'hC000};
        logic [15:0] tb[6] = '{16'h4000, 16'h3E01, 16'h7BFF, 16'h3800, 16'h3C00, 16'h3E00};
        logic [15:0] tp[6] = '{16'h4200, RND_EXP,  16'h7C00, 16'h0000, 16'h3C00, 16'hC200};
        logic [4:0]  tf[6] = '{F_NORM,   F_NORM,   F_INF,    F_ZERO,   F_NORM,   F_NORM};
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{p: tp[i], f: tf[i], lat: 13});
            do_op(ta[i], tb[i], 1'b0);
            e = sb.pop_front();
            checks++; if (producto !== e.p) begin errors++; $display("FAIL normal_prod[%0d] got %h want %h", i, producto, e.p); end
            checks++; if (flags_obs !== e.f) begin errors++; $display("FAIL normal_flags[%0d] got %b want %b", i, flags_obs, e.f); end
            checks++; if (lat_obs !== e.lat) begin errors++; $display("FAIL normal_latency[%0d] got %0d want %0d", i, lat_obs, e.lat); end
            release_result();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || flags_obs !== 5'b0) begin
                errors++;
                $display("FAIL normal_release[%0d] got ov=%b ir=%b fl=%b want ov=0 ir=1 fl=00000", i, out_valid, in_ready, flags_obs);
            end
        end
    endtask

    task automatic test_special;
        logic [15:0] ta[6] = '{16'h7C00, 16'hFC00, 16'h7D00, 16'h0001, 16'h3C00, 16'hBC00};
        logic [15:0] tb[6] = '{16'h0000, 16'h3C00, 16'h7E00, 16'h3C00, 16'h7E55, 16'h0000};
        logic [15:0] tp[6] = '{16'h7E00, 16'hFC00, 16'h7E00, 16'h0000, 16'h7E55, 16'h8000};
        logic [4:0]  tf[6] = '{F_QNAN,   F_INF,    F_SNAN,   F_ZERO,   F_QNAN,   F_ZERO};
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{p: tp[i], f: tf[i], lat: 1});
            do_op(ta[i], tb[i], 1'b0);
            e = sb.pop_front();
            checks++; if (producto !== e.p) begin errors++; $display("FAIL special_prod[%0d] got %h want %h", i, producto, e.p); end
            checks++; if (flags_obs !== e.f) begin errors++; $display("FAIL special_flags[%0d] got %b want %b", i, flags_obs, e.f); end
            checks++; if (lat_obs !== e.lat) begin errors++; $display("FAIL special_latency[%0d] got %0d want %0d", i, lat_obs, e.lat); end
            release_result();
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL special_release[%0d] got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_hold;
        sb.push_back('{p: 16'h4200, f: F_NORM, lat: 13});
        do_op(16'h3E00, 16'h4000, 1'b1);
        e = sb.pop_front();
        checks++; if (producto !== e.p) begin errors++; $display("FAIL hold_prod got %h want %h", producto, e.p); end
        checks++; if (lat_obs !== e.lat) begin errors++; $display("FAIL hold_latency got %0d want %0d", lat_obs, e.lat); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checks++;
            if (producto !== e.p || flags_obs !== e.f || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d] got p=%h fl=%b ov=%b ir=%b want p=%h fl=%b ov=1 ir=0", i, producto, flags_obs, out_valid, in_ready, e.p, e.f);
            end
        end
        in_valid = 1'b0;
        release_result();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        out_ready = 1'b1;
        sb.push_back('{p: 16'hC200, f: F_NORM, lat: 13});
        sb.push_back('{p: 16'h4000, f: F_NORM, lat: 13});
        do_op(16'hC000, 16'h3E00, 1'b0);
        e = sb.pop_front();
        checks++; if (producto !== e.p || flags_obs !== e.f) begin errors++; $display("FAIL b2b_first got p=%h fl=%b want p=%h fl=%b", producto, flags_obs, e.p, e.f); end
        checks++; if (lat_obs !== e.lat) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", lat_obs, e.lat); end
        // New operands offered in DONE together with out_ready: only the result is taken.
        @(negedge clk);
        a = 16'h3C00; b = 16'h4000; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_take got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat_obs = 1;
        while (out_valid !== 1'b1 && lat_obs < 40) begin
            @(posedge clk); #1;
            lat_obs++;
        end
        e = sb.pop_front();
        checks++; if (producto !== e.p || flags_obs !== e.f) begin errors++; $display("FAIL b2b_second got p=%h fl=%b want p=%h fl=%b", producto, flags_obs, e.p, e.f); end
        checks++; if (lat_obs !== e.lat) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", lat_obs, e.lat); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_one_cycle got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        a = 16'h3E00; b = 16'h4000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_handshake got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
        checks++; if (producto !== 16'h0 || flags_obs !== 5'b0) begin errors++; $display("FAIL midrst_outputs got p=%h fl=%b want p=0000 fl=00000", producto, flags_obs); end
        @(negedge clk);
        rst = 1'b1;
        sb.push_back('{p: 16'h3C00, f: F_NORM, lat: 13});
        do_op(16'h3C00, 16'h3C00, 1'b0);
        e = sb.pop_front();
        checks++; if (producto !== e.p || flags_obs !== e.f) begin errors++; $display("FAIL midrst_next got p=%h fl=%b want p=%h fl=%b", producto, flags_obs, e.p, e.f); end
        checks++; if (lat_obs !== e.lat) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat_obs, e.lat); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
